// File: rtl/sr_pkg.sv
// Shared types and helpers for the SR flip-flop command driver.
package sr_pkg;

    // Driver FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    // Command encoding as {s, r}; the two bits are never both set.
    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_SET  = 2'b10;
    localparam logic [1:0] CMD_RST  = 2'b01;

    // Pulse command that drives the flop toward the given level.
    function automatic logic [1:0] cmd_for(input logic level);
        return level ? CMD_SET : CMD_RST;
    endfunction

    // Counter width: wide enough for any of the timing/retry values minus one.
    function automatic int cnt_width(input int gap, input int fb_lat, input int max_retry);
        int m;
        m = gap;
        if (fb_lat > m) m = fb_lat;
        if (max_retry + 1 > m) m = max_retry + 1;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sr_dcnt.sv
// Loadable down-counter with zero flag; times both the WAIT and GAP phases.
module sr_dcnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sr_drive.sv
// Command-side SR flop driver: encodes requested levels into single-cycle
// set/reset pulses, confirms them via q feedback, retries on mismatch and
// keeps a shadow of the last confirmed level. All outputs are registered.
module sr_drive
    import sr_pkg::*;
#(
    parameter int GAP       = 2,
    parameter int FB_LAT    = 1,
    parameter int MAX_RETRY = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic s,
    output logic r,
    input  logic q_fb,
    output logic shadow_q,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int CW = cnt_width(GAP, FB_LAT, MAX_RETRY);
    typedef logic [CW-1:0] cnt_t;

    // Phase counter holds "cycles remaining minus one", so zero marks the last cycle.
    localparam cnt_t WAIT_LOAD   = cnt_t'(FB_LAT - 1);
    localparam cnt_t GAP_LOAD    = cnt_t'(GAP - 1);
    localparam cnt_t RETRY_LIMIT = cnt_t'(MAX_RETRY);

    state_e     state_q, state_d;
    state_e     exit_q, exit_d;
    logic       target_q, target_d;
    cnt_t       retry_q, retry_d;
    logic [1:0] cmd_q, cmd_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       shadow_lvl_q, shadow_d;
    logic       ready_q;
    logic       busy_q;

    logic       cnt_load;
    cnt_t       cnt_load_val;
    logic       cnt_dec;
    logic       cnt_zero;

    sr_dcnt #(
        .W (CW)
    ) u_dcnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next-state and next-output logic; pulses are launched on entry to PULSE.
    always_comb begin
        state_d      = state_q;
        exit_d       = exit_q;
        target_d     = target_q;
        retry_d      = retry_q;
        cmd_d        = CMD_NONE;
        done_d       = 1'b0;
        err_d        = err_q;
        shadow_d     = shadow_lvl_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    target_d = req_level;
                    err_d    = 1'b0;
                    retry_d  = '0;
                    // Already at the requested level and confirmed: complete without a pulse.
                    if ((req_level == shadow_lvl_q) && (q_fb == req_level)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_PULSE;
                        cmd_d   = cmd_for(req_level);
                    end
                end
            end
            S_PULSE: begin
                state_d      = S_WAIT;
                cnt_load     = 1'b1;
                cnt_load_val = WAIT_LOAD;
            end
            S_WAIT: begin
                if (cnt_zero) begin
                    state_d      = S_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LOAD;
                    if (q_fb == target_q) begin
                        shadow_d = target_q;
                        done_d   = 1'b1;
                        exit_d   = S_IDLE;
                    end else if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + cnt_t'(1);
                        exit_d  = S_PULSE;
                    end else begin
                        // Out of attempts: report and record what the flop actually holds.
                        err_d    = 1'b1;
                        done_d   = 1'b1;
                        shadow_d = q_fb;
                        exit_d   = S_IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    state_d = exit_q;
                    if (exit_q == S_PULSE) begin
                        cmd_d = cmd_for(target_q);
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset truncates any pulse in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            exit_q       <= S_IDLE;
            target_q     <= 1'b0;
            retry_q      <= '0;
            cmd_q        <= CMD_NONE;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            shadow_lvl_q <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            exit_q       <= exit_d;
            target_q     <= target_d;
            retry_q      <= retry_d;
            cmd_q        <= cmd_d;
            done_q       <= done_d;
            err_q        <= err_d;
            shadow_lvl_q <= shadow_d;
            ready_q      <= (state_d == S_IDLE);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign s         = cmd_q[1];
    assign r         = cmd_q[0];
    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign shadow_q  = shadow_lvl_q;

endmodule

// File: tb/tb_sr_drive.sv
// Self-checking bench for sr_drive: a per-cycle expectation timeline is
// planned from the timing rules whenever a request is accepted or reset hits.
module tb_sr_drive;

    localparam int GAP       = 2;
    localparam int FB_LAT    = 1;
    localparam int MAX_RETRY = 3;
    localparam int PER       = 1 + FB_LAT + GAP;
    localparam int PLAN_N    = 16384;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_level = 1'b0;
    logic req_ready, s, r, shadow_q, busy, done, err;
    logic q_fb;

    // Downstream flop model and a stuck-at fault injector on its q.
    logic flop_q = 1'b0;
    logic stuck_en = 1'b0;
    logic stuck_val = 1'b0;
    assign q_fb = stuck_en ? stuck_val : flop_q;

    always @(posedge clk) begin
        if (s) flop_q <= 1'b1;
        else if (r) flop_q <= 1'b0;
    end

    sr_drive #(
        .GAP       (GAP),
        .FB_LAT    (FB_LAT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_level (req_level),
        .req_ready (req_ready),
        .s         (s),
        .r         (r),
        .q_fb      (q_fb),
        .shadow_q  (shadow_q),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int failed = 0;

    task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, c, got, exp);
        end
    endtask

    // Expected observation per cycle: {ready, busy, s, r, done, err, shadow}.
    typedef struct packed {
        logic ready;
        logic busy;
        logic s;
        logic r;
        logic done;
        logic err;
        logic shadow;
    } obs_t;

    obs_t plan[PLAN_N];
    int   plan_end = -1;
    logic st_err = 1'b0;
    logic st_shadow = 1'b0;
    logic armed = 1'b0;

    function automatic obs_t expect_at(input int c);
        obs_t o;
        if (c <= plan_end && c < PLAN_N) begin
            o = plan[c];
        end else begin
            o = '0;
            o.ready  = 1'b1;
            o.err    = st_err;
            o.shadow = st_shadow;
        end
        return o;
    endfunction

    // Plan the outputs of a request accepted so that its cycle 1 is absolute cycle b.
    task automatic plan_accept(input int b, input logic lvl, input obs_t prev);
        obs_t o;
        logic succ;
        logic fin_sh;
        int   n;
        int   done_c;
        if (lvl == prev.shadow && q_fb == lvl) begin
            o = '0;
            o.ready  = 1'b1;
            o.done   = 1'b1;
            o.shadow = prev.shadow;
            if (b < PLAN_N) plan[b] = o;
            plan_end  = b;
            st_err    = 1'b0;
            st_shadow = prev.shadow;
        end else begin
            succ   = stuck_en ? (lvl == stuck_val) : 1'b1;
            n      = succ ? 1 : MAX_RETRY + 1;
            fin_sh = succ ? lvl : stuck_val;
            done_c = b + (n - 1) * PER + 1 + FB_LAT;
            for (int i = 0; i < n * PER; i++) begin
                o = '0;
                o.busy = 1'b1;
                if (i % PER == 0) begin
                    o.s = lvl;
                    o.r = ~lvl;
                end
                o.done   = (b + i == done_c);
                o.err    = (b + i >= done_c) ? ~succ : 1'b0;
                o.shadow = (b + i >= done_c) ? fin_sh : prev.shadow;
                if (b + i < PLAN_N) plan[b + i] = o;
            end
            plan_end  = b + n * PER - 1;
            st_err    = ~succ;
            st_shadow = fin_sh;
        end
    endtask

    int   s_log[$];
    int   r_log[$];
    int   done_log[$];
    int   rdy_rise[$];
    int   rdy_fall[$];
    logic prev_rdy = 1'b0;

    // Compare every cycle against the plan, log events, then plan the next edge.
    always @(negedge clk) begin
        obs_t g;
        obs_t e;
        int   c;
        c = cyc;
        g = {req_ready, busy, s, r, done, err, shadow_q};
        e = expect_at(c);
        if (armed) chk("cycle{rdy,busy,s,r,done,err,shadow}", c, {25'b0, g}, {25'b0, e});
        if (s) s_log.push_back(c);
        if (r) r_log.push_back(c);
        if (done) done_log.push_back(c);
        if (req_ready && !prev_rdy) rdy_rise.push_back(c);
        if (!req_ready && prev_rdy) rdy_fall.push_back(c);
        prev_rdy = req_ready;
        if (!rst_n) begin
            if (c + 1 < PLAN_N) plan[c + 1] = '0;
            plan_end  = c + 1;
            st_err    = 1'b0;
            st_shadow = 1'b0;
            armed     = 1'b1;
        end else if (armed && req_valid && e.ready) begin
            plan_accept(c + 1, req_level, e);
        end
    end

    function automatic int at(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    task automatic clear_logs();
        s_log.delete();
        r_log.delete();
        done_log.delete();
        rdy_rise.delete();
        rdy_fall.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Present one request; acc is the cycle in which the handshake completed.
    task automatic send(input logic lvl, output int acc);
        int   n;
        logic rdy;
        n = 0;
        acc = -1;
        req_valid = 1'b1;
        req_level = lvl;
        rdy = 1'b0;
        while (!rdy && n <= 200) begin
            @(negedge clk);
            rdy = req_ready;
            if (rdy) acc = cyc;
            n++;
        end
        if (!rdy) chk("accept_timeout", cyc, 0, 1);
        @(posedge clk);
        #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int   n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n <= 200) begin
            @(negedge clk);
            rdy = req_ready;
            n++;
        end
        if (!rdy) chk("ready_timeout", cyc, 0, 1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        int a2;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Basic set from reset.
        clear_logs();
        send(1'b1, a);
        idle(6);
        chk("set_pulse_count", cyc, s_log.size(), 1);
        chk("set_pulse_cycle", cyc, at(s_log, 0) - a, 1);
        chk("set_done_cycle", cyc, at(done_log, 0) - a, 3);
        chk("set_ready_cycle", cyc, at(rdy_rise, 0) - a, 5);
        chk("set_shadow", cyc, shadow_q, 1);
        chk("set_err", cyc, err, 0);

        // No-op request at the current level.
        clear_logs();
        send(1'b1, a);
        idle(3);
        chk("noop_pulses", cyc, s_log.size() + r_log.size(), 0);
        chk("noop_done_cycle", cyc, at(done_log, 0) - a, 1);
        chk("noop_ready_drops", cyc, rdy_fall.size(), 0);

        // Back-to-back set then reset with valid held.
        send(1'b0, a);
        idle(5);
        clear_logs();
        send(1'b1, a);
        send(1'b0, a2);
        idle(6);
        chk("b2b_second_accept", cyc, a2 - a, 5);
        chk("b2b_r_pulse", cyc, at(r_log, 0) - a, 6);
        chk("b2b_shadow", cyc, shadow_q, 0);

        // Stuck-at-0 feedback exhausts all attempts.
        stuck_en = 1'b1;
        stuck_val = 1'b0;
        clear_logs();
        send(1'b1, a);
        idle(18);
        chk("stuck_pulse_count", cyc, s_log.size(), 4);
        for (int k = 0; k < 4; k++) chk("stuck_pulse_cycle", cyc, at(s_log, k) - a, 1 + 4 * k);
        chk("stuck_done_cycle", cyc, at(done_log, 0) - a, 15);
        chk("stuck_err", cyc, err, 1);
        chk("stuck_shadow", cyc, shadow_q, 0);

        // Recovery once feedback is released.
        stuck_en = 1'b0;
        clear_logs();
        send(1'b1, a);
        @(negedge clk);
        chk("recover_err_cleared", cyc, err, 0);
        idle(5);
        chk("recover_pulse_count", cyc, s_log.size(), 1);
        chk("recover_done_cycle", cyc, at(done_log, 0) - a, 3);
        chk("recover_shadow", cyc, shadow_q, 1);
        chk("recover_err", cyc, err, 0);

        // Reset during WAIT of a set request.
        send(1'b0, a);
        idle(5);
        send(1'b1, a);
        idle(1);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_outputs", cyc, {req_ready, busy, s, r, done, err, shadow_q}, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_low", cyc, req_ready, 0);
        @(negedge clk);
        chk("midrst_ready_back", cyc, req_ready, 1);
        idle(1);

        // Randomized traffic: requests, fault toggles and occasional resets.
        for (int it = 0; it < 200; it++) begin
            int sel;
            sel = $urandom_range(0, 11);
            if (sel == 0) begin
                send(1'($urandom_range(0, 1)), a);
                idle($urandom_range(0, 12));
                rst_n = 1'b0;
                idle($urandom_range(1, 2));
                rst_n = 1'b1;
                idle(1);
            end else if (sel <= 2) begin
                wait_ready();
                stuck_en = 1'($urandom_range(0, 1));
                stuck_val = 1'($urandom_range(0, 1));
            end else begin
                send(1'($urandom_range(0, 1)), a);
                if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 4));
            end
        end
        idle(25);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
